// File: rtl/pio_in_edge_irq.sv
// Parametrised Avalon-MM input PIO slave: synchronised input data register,
// per-bit edge capture, writable interrupt mask and level interrupt.
module pio_in_edge_irq #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned BIT_CLEAR   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edgecapture_next;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_wd;

  assign sync      = sync_q[SYNC_STAGES-1];
  assign wr_en     = chipselect & ~write_n;
  assign unused_wd = ^writedata;

  // Synchroniser chain for the asynchronous input bus
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= in_port;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Previous synchronised value for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
    end else begin
      prev <= sync;
    end
  end

  // Per-bit edge detect selected by EDGE_TYPE
  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = sync & ~prev;
      1:       edge_det = ~sync & prev;
      default: edge_det = (sync & ~prev) | (~sync & prev);
    endcase
  end

  // Edgecapture next state: software clear first, then OR in new edges so set wins
  always_comb begin
    edgecapture_next = edgecapture;
    if (wr_en && (address == 2'd3)) begin
      if (BIT_CLEAR != 0) begin
        edgecapture_next = edgecapture & ~writedata[WIDTH-1:0];
      end else begin
        edgecapture_next = '0;
      end
    end
    edgecapture_next = edgecapture_next | edge_det;
  end

  // Edgecapture and interrupt mask registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecapture <= '0;
      irqmask     <= '0;
    end else begin
      edgecapture <= edgecapture_next;
      if (wr_en && (address == 2'd2)) begin
        irqmask <= writedata[WIDTH-1:0];
      end
    end
  end

  // Read mux, zero-extended to the bus width
  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = sync;
      2'd2:    rd_mux[WIDTH-1:0] = irqmask;
      2'd3:    rd_mux[WIDTH-1:0] = edgecapture;
      default: rd_mux = '0;
    endcase
  end

  // Registered read data, updated every cycle regardless of chipselect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

  assign irq = |(edgecapture & irqmask);

endmodule
